simple_system_host_arb: RTL and testbench

- Round-robin arbiter that lets NrHosts bus hosts (core data port, debug/DMA masters) share one device port, e.g. RAM port A or a bus host slot.
- Uses the core's req/gnt/rvalid protocol, with in-order pipelined responses.
- Records the granted host ID per outstanding transaction and routes each response back to the host that issued it.

---
 rtl/simple_system_arb_id_fifo.sv | 66 ++++++
 rtl/simple_system_host_arb.sv | 119 +++++++++++
 tb/tb_simple_system_host_arb.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/simple_system_arb_id_fifo.sv
// Small synchronous FIFO holding the host ID of each granted-but-unanswered
// transaction. Depth need not be a power of two; pointers wrap explicitly.
module simple_system_arb_id_fifo #(
    parameter int Depth = 2,
    parameter int Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);

    // Next-state: write at tail, advance pointers with explicit wrap, track occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (pop_i && !push_i) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer/occupancy registers; reset empties the queue.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/simple_system_host_arb.sv
// Round-robin arbiter sharing one req/gnt/rvalid device port among NrHosts
// hosts. Responses are in order; the ID FIFO routes each back to its issuer.
module simple_system_host_arb #(
    parameter int NrHosts        = 2,
    parameter int DataWidth      = 32,
    parameter int AddrWidth      = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NrHosts-1:0]     host_req_i,
    output logic [NrHosts-1:0]     host_gnt_o,
    input  logic [AddrWidth-1:0]   host_addr_i  [NrHosts],
    input  logic [NrHosts-1:0]     host_we_i,
    input  logic [DataWidth/8-1:0] host_be_i    [NrHosts],
    input  logic [DataWidth-1:0]   host_wdata_i [NrHosts],
    output logic [NrHosts-1:0]     host_rvalid_o,
    output logic [DataWidth-1:0]   host_rdata_o [NrHosts],
    output logic [NrHosts-1:0]     host_err_o,
    output logic                   dev_req_o,
    input  logic                   dev_gnt_i,
    output logic [AddrWidth-1:0]   dev_addr_o,
    output logic                   dev_we_o,
    output logic [DataWidth/8-1:0] dev_be_o,
    output logic [DataWidth-1:0]   dev_wdata_o,
    input  logic                   dev_rvalid_i,
    input  logic [DataWidth-1:0]   dev_rdata_i,
    input  logic                   dev_err_i,
    output logic                   protocol_err_o
);
    localparam int IdW = (NrHosts > 1) ? $clog2(NrHosts) : 1;

    logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
    logic           protocol_err_q, protocol_err_d;
    logic [IdW-1:0] winner;
    logic [IdW-1:0] fifo_head;
    logic           fifo_full, fifo_empty;
    logic           any_req, grant, resp_valid;

    // First requesting host at or after ptr, wrapping at NrHosts (not 2**IdW).
    function automatic logic [IdW-1:0] pick_winner(input logic [NrHosts-1:0] req,
                                                   input logic [IdW-1:0]     ptr);
        logic [IdW-1:0] w;
        logic           found;
        int             idx;
        w     = '0;
        found = 1'b0;
        for (int k = 0; k < NrHosts; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NrHosts) idx = idx - NrHosts;
            if (!found && req[idx]) begin
                w     = IdW'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    // Arbitration, device mux, grant and response routing; all gated by reset.
    always_comb begin
        winner     = pick_winner(host_req_i, rr_ptr_q);
        any_req    = |host_req_i;
        dev_req_o  = any_req & ~fifo_full & ~rst_i;
        grant      = dev_req_o & dev_gnt_i;
        resp_valid = dev_rvalid_i & ~fifo_empty & ~rst_i;

        dev_addr_o  = '0;
        dev_we_o    = 1'b0;
        dev_be_o    = '0;
        dev_wdata_o = '0;
        if (any_req) begin
            dev_addr_o  = host_addr_i[winner];
            dev_we_o    = host_we_i[winner];
            dev_be_o    = host_be_i[winner];
            dev_wdata_o = host_wdata_i[winner];
        end

        for (int i = 0; i < NrHosts; i++) begin
            host_gnt_o[i]    = grant && (winner == IdW'(i));
            host_rvalid_o[i] = resp_valid && (fifo_head == IdW'(i));
            host_err_o[i]    = resp_valid && (fifo_head == IdW'(i)) && dev_err_i;
            host_rdata_o[i]  = dev_rdata_i;
        end

        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            rr_ptr_d = (winner == IdW'(NrHosts - 1)) ? '0 : winner + 1'b1;
        end

        protocol_err_d = protocol_err_q | (dev_rvalid_i & fifo_empty & ~rst_i);
    end

    assign protocol_err_o = protocol_err_q;

    // Round-robin pointer and sticky protocol error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q       <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    simple_system_arb_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (grant),
        .data_i  (winner),
        .pop_i   (resp_valid),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );
endmodule

// File: tb/tb_simple_system_host_arb.sv
// Directed bench: a 2-host instance for reset/fairness/backpressure/stall/
// protocol-error cases and a 3-host instance for non-power-of-2 wrap.
module tb_simple_system_host_arb;
    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- 2-host instance ----------------
    logic        a_rst;
    logic [1:0]  a_req, a_we, a_gnt, a_hrvalid, a_herr;
    logic [31:0] a_addr [2];
    logic [3:0]  a_be [2];
    logic [31:0] a_wdata [2];
    logic [31:0] a_hrdata [2];
    logic        a_dreq, a_dgnt, a_dwe, a_rvalid, a_derr, a_perr;
    logic [31:0] a_daddr, a_dwdata, a_rdata;
    logic [3:0]  a_dbe;

    simple_system_host_arb #(.NrHosts(2), .DataWidth(32), .AddrWidth(32), .MaxOutstanding(2)) dut (
        .clk_i(clk_i), .rst_i(a_rst),
        .host_req_i(a_req), .host_gnt_o(a_gnt), .host_addr_i(a_addr), .host_we_i(a_we),
        .host_be_i(a_be), .host_wdata_i(a_wdata), .host_rvalid_o(a_hrvalid),
        .host_rdata_o(a_hrdata), .host_err_o(a_herr),
        .dev_req_o(a_dreq), .dev_gnt_i(a_dgnt), .dev_addr_o(a_daddr), .dev_we_o(a_dwe),
        .dev_be_o(a_dbe), .dev_wdata_o(a_dwdata), .dev_rvalid_i(a_rvalid),
        .dev_rdata_i(a_rdata), .dev_err_i(a_derr), .protocol_err_o(a_perr)
    );

    // ---------------- 3-host instance ----------------
    logic        b_rst;
    logic [2:0]  b_req, b_we, b_gnt, b_hrvalid, b_herr;
    logic [31:0] b_addr [3];
    logic [3:0]  b_be [3];
    logic [31:0] b_wdata [3];
    logic [31:0] b_hrdata [3];
    logic        b_dreq, b_dgnt, b_dwe, b_rvalid, b_derr, b_perr;
    logic [31:0] b_daddr, b_dwdata, b_rdata;
    logic [3:0]  b_dbe;

    simple_system_host_arb #(.NrHosts(3), .DataWidth(32), .AddrWidth(32), .MaxOutstanding(2)) dut3 (
        .clk_i(clk_i), .rst_i(b_rst),
        .host_req_i(b_req), .host_gnt_o(b_gnt), .host_addr_i(b_addr), .host_we_i(b_we),
        .host_be_i(b_be), .host_wdata_i(b_wdata), .host_rvalid_o(b_hrvalid),
        .host_rdata_o(b_hrdata), .host_err_o(b_herr),
        .dev_req_o(b_dreq), .dev_gnt_i(b_dgnt), .dev_addr_o(b_daddr), .dev_we_o(b_dwe),
        .dev_be_o(b_dbe), .dev_wdata_o(b_dwdata), .dev_rvalid_i(b_rvalid),
        .dev_rdata_i(b_rdata), .dev_err_i(b_derr), .protocol_err_o(b_perr)
    );

    logic [1:0] exp_gnt, prev_gnt;

    initial begin
        a_rst = 1'b1; a_req = 2'b11; a_we = 2'b10; a_dgnt = 1'b1;
        a_rvalid = 1'b0; a_rdata = '0; a_derr = 1'b0;
        a_addr[0] = 32'h0000_1000; a_addr[1] = 32'h0000_2000;
        a_be[0] = 4'hF; a_be[1] = 4'h3;
        a_wdata[0] = 32'h1111_1111; a_wdata[1] = 32'h2222_2222;
        b_rst = 1'b1; b_req = '0; b_we = '0; b_dgnt = 1'b1;
        b_rvalid = 1'b0; b_rdata = '0; b_derr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b_addr[i] = 32'h100 * (i + 1); b_be[i] = 4'hF; b_wdata[i] = '0;
        end

        // Reset with both hosts requesting: everything off.
        #1;
        chk("rst_gnt_c0", a_gnt, 2'b00);
        chk("rst_dreq_c0", a_dreq, 1'b0);
        cyc();
        chk("rst_gnt_c1", a_gnt, 2'b00);
        chk("rst_dreq_c1", a_dreq, 1'b0);
        chk("rst_rvalid", a_hrvalid, 2'b00);
        cyc();
        a_rst = 1'b0;
        #3;
        chk("post_rst_gnt", a_gnt, 2'b01);
        chk("post_rst_perr", a_perr, 1'b0);
        chk("mux_addr_h0", a_daddr, 32'h0000_1000);
        chk("mux_wdata_h0", a_dwdata, 32'h1111_1111);
        chk("mux_we_h0", a_dwe, 1'b0);
        chk("mux_be_h0", a_dbe, 4'hF);

        // Fairness: alternating grants, each response one cycle after its grant.
        prev_gnt = 2'b01;
        for (int n = 1; n < 4; n++) begin
            cyc();
            a_rvalid = 1'b1;
            a_rdata  = 32'hA5A5_0000 + n - 1;
            #3;
            exp_gnt = (n % 2 == 1) ? 2'b10 : 2'b01;
            chk("fair_gnt", a_gnt, exp_gnt);
            chk("fair_rvalid", a_hrvalid, prev_gnt);
            chk("fair_rdata", a_hrdata[(prev_gnt == 2'b10) ? 1 : 0], 32'hA5A5_0000 + n - 1);
            chk("fair_err", a_herr, 2'b00);
            prev_gnt = exp_gnt;
        end
        chk("mux_addr_h1", a_daddr, 32'h0000_2000);
        chk("mux_we_h1", a_dwe, 1'b1);
        chk("mux_be_h1", a_dbe, 4'h3);
        cyc();
        a_req = 2'b00; a_rdata = 32'hA5A5_0003;
        #3;
        chk("drain_rvalid", a_hrvalid, 2'b10);
        chk("drain_rdata", a_hrdata[1], 32'hA5A5_0003);
        chk("idle_gnt", a_gnt, 2'b00);
        chk("idle_dreq", a_dreq, 1'b0);
        chk("idle_addr", a_daddr, 32'h0);

        // Backpressure: two grants fill the FIFO, then a one-cycle bubble after a pop.
        cyc();
        a_req = 2'b11; a_rvalid = 1'b0;
        #3;
        chk("bp_gnt0", a_gnt, 2'b01);
        chk("bp_no_rvalid", a_hrvalid, 2'b00);
        cyc();
        #3;
        chk("bp_gnt1", a_gnt, 2'b10);
        cyc();
        #3;
        chk("bp_full_dreq", a_dreq, 1'b0);
        chk("bp_full_gnt", a_gnt, 2'b00);
        cyc();
        a_rvalid = 1'b1;
        #3;
        chk("bp_pop_rvalid", a_hrvalid, 2'b01);
        chk("bp_pop_dreq", a_dreq, 1'b0);
        chk("bp_pop_gnt", a_gnt, 2'b00);
        cyc();
        a_rvalid = 1'b0;
        #3;
        chk("bp_resume_dreq", a_dreq, 1'b1);
        chk("bp_resume_gnt", a_gnt, 2'b01);
        cyc();
        a_req = 2'b00; a_rvalid = 1'b1;
        #3;
        chk("bp_drain1", a_hrvalid, 2'b10);
        cyc();
        #3;
        chk("bp_drain0", a_hrvalid, 2'b01);

        // Device stall: host 1 held off by dev_gnt_i=0 for three cycles.
        cyc();
        a_rvalid = 1'b0; a_req = 2'b10; a_dgnt = 1'b0; a_addr[1] = 32'h0010_0010;
        for (int s = 0; s < 3; s++) begin
            #3;
            chk("stall_dreq", a_dreq, 1'b1);
            chk("stall_addr", a_daddr, 32'h0010_0010);
            chk("stall_gnt", a_gnt, 2'b00);
            cyc();
        end
        a_dgnt = 1'b1;
        #3;
        chk("stall_release_gnt", a_gnt, 2'b10);

        // Exactly one outstanding; a second response is unexpected.
        cyc();
        a_req = 2'b00; a_rvalid = 1'b1;
        #3;
        chk("stall_resp", a_hrvalid, 2'b10);
        chk("perr_before", a_perr, 1'b0);
        cyc();
        #3;
        chk("perr_no_rvalid", a_hrvalid, 2'b00);
        chk("perr_not_yet", a_perr, 1'b0);
        cyc();
        a_rvalid = 1'b0;
        #3;
        chk("perr_set", a_perr, 1'b1);
        cyc();
        cyc();
        #3;
        chk("perr_sticky", a_perr, 1'b1);

        // Response during reset is ignored and not flagged.
        cyc();
        a_rst = 1'b1; a_rvalid = 1'b1; a_req = 2'b11;
        #3;
        chk("rst_resp_rvalid", a_hrvalid, 2'b00);
        chk("rst_resp_gnt", a_gnt, 2'b00);
        cyc();
        a_rst = 1'b0; a_rvalid = 1'b0; a_req = 2'b00;
        #3;
        chk("perr_cleared", a_perr, 1'b0);
        cyc();
        #3;
        chk("perr_stays_clear", a_perr, 1'b0);

        // 3-host instance: move rr_ptr to 2, then check wrap 2 -> 0.
        cyc();
        b_rst = 1'b1;
        cyc();
        b_rst = 1'b0; b_req = 3'b010;
        #3;
        chk("h3_gnt1", b_gnt, 3'b010);
        cyc();
        b_req = 3'b000; b_rvalid = 1'b1;
        #3;
        chk("h3_resp1", b_hrvalid, 3'b010);
        cyc();
        b_req = 3'b101; b_rvalid = 1'b0;
        #3;
        chk("h3_gnt2", b_gnt, 3'b100);
        chk("h3_addr2", b_daddr, 32'h300);
        cyc();
        b_req = 3'b001; b_rvalid = 1'b1; b_derr = 1'b0;
        #3;
        chk("h3_gnt0_wrap", b_gnt, 3'b001);
        chk("h3_resp2", b_hrvalid, 3'b100);
        chk("h3_err2", b_herr, 3'b000);
        cyc();
        b_req = 3'b000; b_derr = 1'b1;
        #3;
        chk("h3_resp0", b_hrvalid, 3'b001);
        chk("h3_err0", b_herr, 3'b001);
        cyc();
        b_rvalid = 1'b0; b_derr = 1'b0;
        #3;
        chk("h3_perr", b_perr, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
